// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - access-type and funct3 encodings plus FSM state type for csr_access_unit
package csr_pkg;

    localparam logic [1:0] ACC_READ_ONLY = 2'b00;
    localparam logic [1:0] ACC_WRITE     = 2'b01;
    localparam logic [1:0] ACC_SET       = 2'b10;
    localparam logic [1:0] ACC_CLEAR     = 2'b11;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } csr_state_e;

    // funct3[1:0] == 00 encodes no CSR operation at all
    function automatic logic f3_is_csr(input logic [2:0] f3);
        return f3[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - CSR read/modify/write sequencer; optional macro CSR_ILLEGAL_CHECK_EN adds resp_illegal
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_csr,
    input  logic [4:0]      req_rs1,
    input  logic [XLEN-1:0] req_rs1_val,
    input  logic [4:0]      req_rd,
    output logic [11:0]     csr_number,
    output logic [1:0]      csr_access_type,
    output logic [XLEN-1:0] csr_in,
    input  logic [XLEN-1:0] csr_out,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [4:0]      resp_rd,
    output logic [XLEN-1:0] resp_data,
`ifdef CSR_ILLEGAL_CHECK_EN
    output logic            resp_illegal,
`endif
    output logic            resp_we
);

    csr_state_e      state_q;
    logic [11:0]     num_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] operand_q;
    logic [4:0]      rd_q;
    logic            wr_q;
    logic [XLEN-1:0] old_q;
    logic            illegal_q;

    logic            accept;
    logic [XLEN-1:0] operand;
    logic            wants_write;
    logic            illegal;

    assign accept      = req_valid && req_ready;
    assign operand     = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1} : req_rs1_val;
    assign wants_write = f3_is_csr(req_funct3) && ((req_funct3[1:0] == 2'b01) || (req_rs1 != 5'd0));

`ifdef CSR_ILLEGAL_CHECK_EN
    assign illegal      = wants_write && (req_csr[11:10] == 2'b11);
    assign resp_illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            num_q     <= 12'd0;
            op_q      <= ACC_READ_ONLY;
            operand_q <= '0;
            rd_q      <= 5'd0;
            wr_q      <= 1'b0;
            old_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        num_q     <= req_csr;
                        op_q      <= req_funct3[1:0];
                        operand_q <= operand;
                        rd_q      <= req_rd;
                        wr_q      <= wants_write && !illegal;
                        illegal_q <= illegal;
                        if (f3_is_csr(req_funct3)) begin
                            state_q <= ST_READ;
                        end else begin
                            old_q   <= '0;
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_READ: begin
                    old_q   <= csr_out;
                    state_q <= wr_q ? ST_WRITE : ST_RESP;
                end
                ST_WRITE: state_q <= ST_RESP;
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // funct3[1:0] of RW/RS/RC maps one-to-one onto WRITE/SET/CLEAR; reset masks
    // the write so a reset landing in WRITE never reaches the register file.
    assign csr_access_type = ((state_q == ST_WRITE) && !reset) ? op_q : ACC_READ_ONLY;
    assign csr_number      = num_q;
    assign csr_in          = operand_q;
    assign req_ready       = (state_q == ST_IDLE);
    assign resp_valid      = (state_q == ST_RESP);
    assign resp_rd         = rd_q;
    assign resp_data       = old_q;
    assign resp_we         = (rd_q != 5'd0) && (op_q != 2'b00) && !illegal_q;

endmodule
